// File: rtl/soundmixer.sv
// Stereo mixer: NCH gained/panned 8-bit channels plus filtered pulse lines, saturated to 16 bits,
// one sample per DECIM clocks over valid/ready; also slices linein into tapein. Option: SOUNDMIXER_MA_EN.
module soundmixer #(
  parameter int NCH     = 8,
  parameter int NPULSE  = 4,
  parameter int DECIM   = 256,
  parameter int MA_LOG2 = 2,
  parameter int HYST    = 4
) (
  input  logic                clk12,
  input  logic                reset,
  input  logic [NPULSE-1:0]   pulses,
  input  logic [8*NCH-1:0]    ch_data,
  input  logic [3*NCH-1:0]    ch_gain,
  input  logic [2*NCH-1:0]    ch_pan,
  output logic [15:0]         out_l,
  output logic [15:0]         out_r,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                overrun,
  input  logic [15:0]         linein,
  output logic                tapein
);
  localparam int CW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int KW = $clog2(NCH + 1);
  localparam int AW = 16 + $clog2(NCH + 1) + 1;

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_SAT, S_OUT} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [KW-1:0]   idx_q, idx_d;
  logic [AW-1:0]   acc_l_q, acc_l_d, acc_r_q, acc_r_d;
  logic [15:0]     out_l_q, out_l_d, out_r_q, out_r_d;
  logic            vld_q, vld_d, ovr_q, ovr_d, tape_q, tape_d;
  logic            tick;
  logic [3:0]      pcnt;
  logic [7:0]      pv, pavg;
  logic [7:0]      sel_data, line8;
  logic [2:0]      sel_gain;
  logic [1:0]      sel_pan;
  logic [AW-1:0]   term;
  logic [15:0]     sat_l, sat_r;
  logic            unused_line_lsb;

  assign tick = (cnt_q == CW'(DECIM - 1));
  assign unused_line_lsb = ^linein[7:0];

  always_comb begin
    pcnt = '0;
    for (int i = 0; i < NPULSE; i++) pcnt = pcnt + 4'(pulses[i]);
  end
  assign pv = {pcnt, 4'h0};

`ifdef SOUNDMIXER_MA_EN
  localparam int DEPTH = 1 << MA_LOG2;
  localparam int PW    = (MA_LOG2 > 0) ? MA_LOG2 : 1;
  localparam int SW    = 8 + MA_LOG2;

  logic [7:0]    ring_q [DEPTH];
  logic [7:0]    ring_d [DEPTH];
  logic [PW-1:0] ptr_q, ptr_d;
  logic [SW-1:0] sum_q, sum_d;

  // The average seen at a tick already includes that tick's pulse value.
  always_comb begin
    ring_d = ring_q;
    ptr_d  = ptr_q;
    sum_d  = sum_q;
    if (tick) begin
      sum_d         = sum_q + SW'(pv) - SW'(ring_q[ptr_q]);
      ring_d[ptr_q] = pv;
      ptr_d         = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + PW'(1);
    end
  end
  assign pavg = 8'(sum_d >> MA_LOG2);

  always_ff @(posedge clk12) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) ring_q[i] <= '0;
      ptr_q <= '0;
      sum_q <= '0;
    end else begin
      ring_q <= ring_d;
      ptr_q  <= ptr_d;
      sum_q  <= sum_d;
    end
  end
`else
  assign pavg = pv;
`endif

  always_comb begin
    sel_data = '0;
    sel_gain = '0;
    sel_pan  = '0;
    for (int i = 0; i < NCH; i++) begin
      if (idx_q == KW'(i)) begin
        sel_data = ch_data[8*i +: 8];
        sel_gain = ch_gain[3*i +: 3];
        sel_pan  = ch_pan[2*i +: 2];
      end
    end
  end
  assign term  = AW'(sel_data) << sel_gain;
  assign sat_l = (acc_l_q > AW'(16'hFFFF)) ? 16'hFFFF : acc_l_q[15:0];
  assign sat_r = (acc_r_q > AW'(16'hFFFF)) ? 16'hFFFF : acc_r_q[15:0];
  assign line8 = {~linein[15], linein[14:8]};

  always_comb begin
    cnt_d   = tick ? '0 : cnt_q + CW'(1);
    state_d = state_q;
    idx_d   = idx_q;
    acc_l_d = acc_l_q;
    acc_r_d = acc_r_q;
    out_l_d = out_l_q;
    out_r_d = out_r_q;
    vld_d   = vld_q;
    ovr_d   = ovr_q;
    tape_d  = tape_q;
    if (vld_q && out_ready) vld_d = 1'b0;
    case (state_q)
      S_IDLE: if (tick) begin
        state_d = S_ACC;
        idx_d   = '0;
        acc_l_d = AW'(pavg) << 7;
        acc_r_d = AW'(pavg) << 7;
      end
      S_ACC: begin
        if (sel_pan[0]) acc_l_d = acc_l_q + term;
        if (sel_pan[1]) acc_r_d = acc_r_q + term;
        idx_d = idx_q + KW'(1);
        if (idx_q == KW'(NCH - 1)) state_d = S_SAT;
      end
      // Clamp and publish share the SAT->OUT edge so the sample is visible at tick+NCH+2.
      S_SAT: begin
        state_d = S_OUT;
        if (!vld_q || out_ready) begin
          out_l_d = sat_l ^ 16'h8000;
          out_r_d = sat_r ^ 16'h8000;
          vld_d   = 1'b1;
        end else begin
          ovr_d = 1'b1;
        end
      end
      S_OUT:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (int'(line8) < 128 - HYST)      tape_d = 1'b0;
    else if (int'(line8) > 128 + HYST) tape_d = 1'b1;
  end

  always_ff @(posedge clk12) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      acc_l_q <= '0;
      acc_r_q <= '0;
      out_l_q <= '0;
      out_r_q <= '0;
      vld_q   <= 1'b0;
      ovr_q   <= 1'b0;
      tape_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      acc_l_q <= acc_l_d;
      acc_r_q <= acc_r_d;
      out_l_q <= out_l_d;
      out_r_q <= out_r_d;
      vld_q   <= vld_d;
      ovr_q   <= ovr_d;
      tape_q  <= tape_d;
    end
  end

  assign out_l     = out_l_q;
  assign out_r     = out_r_q;
  assign out_valid = vld_q;
  assign overrun   = ovr_q;
  assign tapein    = tape_q;
endmodule

// File: tb/tb_soundmixer.sv
// Scoreboard bench for soundmixer: stimulus queues expected {out_l,out_r}; a negedge monitor checks accepted samples.
module tb_soundmixer;
  logic        clk12 = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  pulses = '0;
  logic [63:0] ch_data = '0;
  logic [23:0] ch_gain = '0;
  logic [15:0] ch_pan = '0;
  logic [15:0] out_l, out_r;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        overrun;
  logic [15:0] linein = '0;
  logic        tapein;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  soundmixer dut (
    .clk12(clk12), .reset(reset), .pulses(pulses), .ch_data(ch_data),
    .ch_gain(ch_gain), .ch_pan(ch_pan), .out_l(out_l), .out_r(out_r),
    .out_valid(out_valid), .out_ready(out_ready), .overrun(overrun),
    .linein(linein), .tapein(tapein)
  );

  always #5 clk12 = ~clk12;

  always @(negedge clk12) begin
    if (!reset && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sample_unexpected: got %h_%h, required no sample", out_l, out_r);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if ({out_l, out_r} !== e) begin
          errors++;
          $display("FAIL sample: got %h_%h, required %h_%h", out_l, out_r, e[31:16], e[15:0]);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (5) @(posedge clk12);
    #1 reset = 1'b0;
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk12);
    #1;
  endtask

  task automatic wait_drain(input int budget, input string nm);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk12);
      n++;
    end
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d samples pending, required 0", nm, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic set_all(input logic [7:0] d, input logic [2:0] g, input logic [1:0] p);
    for (int i = 0; i < 8; i++) begin
      ch_data[8*i +: 8] = d;
      ch_gain[3*i +: 3] = g;
      ch_pan[2*i +: 2]  = p;
    end
  endtask

  initial begin
    // Reset state and first-sample latency
    set_all(8'h00, 3'd0, 2'd0);
    out_ready = 1'b1;
    do_reset();
    chk("rst_out_l", {16'h0, out_l}, 32'h0);
    chk("rst_out_r", {16'h0, out_r}, 32'h0);
    chk("rst_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_overrun", {31'h0, overrun}, 32'h0);
    chk("rst_tapein", {31'h0, tapein}, 32'h0);
    exp_q.push_back({16'h8000, 16'h8000});
    edges(264);
    chk("lat_valid_264", {31'h0, out_valid}, 32'h0);
    edges(1);
    chk("lat_valid_265", {31'h0, out_valid}, 32'h1);
    wait_drain(20, "drain_reset");

    // Single channel, gain 4, both sides
    set_all(8'h00, 3'd0, 2'd0);
    ch_data[7:0] = 8'hFF; ch_gain[2:0] = 3'd4; ch_pan[1:0] = 2'd3;
    do_reset();
    exp_q.push_back({16'h8FF0, 16'h8FF0});
    wait_drain(300, "drain_single");

    // Saturation on left, right silent
    set_all(8'hFF, 3'd7, 2'd1);
    do_reset();
    exp_q.push_back({16'h7FFF, 16'h8000});
    wait_drain(300, "drain_sat");

    // Pulse moving average
    set_all(8'h00, 3'd0, 2'd0);
    pulses = 4'b0111;
    do_reset();
`ifdef SOUNDMIXER_MA_EN
    exp_q.push_back({16'h8600, 16'h8600});
    exp_q.push_back({16'h8C00, 16'h8C00});
    exp_q.push_back({16'h9200, 16'h9200});
    exp_q.push_back({16'h9800, 16'h9800});
    exp_q.push_back({16'h9800, 16'h9800});
`else
    for (int i = 0; i < 5; i++) exp_q.push_back({16'h9800, 16'h9800});
`endif
    wait_drain(5 * 256 + 50, "drain_ma");
    pulses = 4'b0000;

    // Handshake backpressure and overrun
    set_all(8'h00, 3'd0, 2'd0);
    ch_data[7:0] = 8'hFF; ch_gain[2:0] = 3'd4; ch_pan[1:0] = 2'd3;
    out_ready = 1'b0;
    do_reset();
    exp_q.push_back({16'h8FF0, 16'h8FF0});
    edges(266);
    chk("hs_valid_first", {31'h0, out_valid}, 32'h1);
    chk("hs_out_l_first", {16'h0, out_l}, 32'h8FF0);
    chk("hs_overrun_before", {31'h0, overrun}, 32'h0);
    ch_data[7:0] = 8'h10;
    edges(260);
    chk("hs_overrun_after", {31'h0, overrun}, 32'h1);
    chk("hs_out_l_held", {16'h0, out_l}, 32'h8FF0);
    chk("hs_out_r_held", {16'h0, out_r}, 32'h8FF0);
    chk("hs_valid_held", {31'h0, out_valid}, 32'h1);
    out_ready = 1'b1;
    edges(1);
    out_ready = 1'b0;
    chk("hs_valid_cleared", {31'h0, out_valid}, 32'h0);
    chk("hs_overrun_sticky", {31'h0, overrun}, 32'h1);
    wait_drain(5, "drain_hs");

    // Reset mid-accumulation discards the sample
    out_ready = 1'b1;
    do_reset();
    edges(260);
    reset = 1'b1;
    edges(2);
    reset = 1'b0;
    begin
      logic seen = 1'b0;
      for (int i = 0; i < 30; i++) begin
        edges(1);
        if (out_valid) seen = 1'b1;
      end
      chk("midreset_no_valid", {31'h0, seen}, 32'h0);
    end

    // Tape slicer hysteresis
    do_reset();
    linein = 16'h0500;
    chk("tape_before_edge", {31'h0, tapein}, 32'h0);
    edges(1);
    chk("tape_high", {31'h0, tapein}, 32'h1);
    linein = 16'h0000;
    edges(1);
    chk("tape_hold_1", {31'h0, tapein}, 32'h1);
    linein = 16'hFB00;
    edges(1);
    chk("tape_low", {31'h0, tapein}, 32'h0);
    linein = 16'h0400;
    edges(1);
    chk("tape_hold_0", {31'h0, tapein}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
